// File: rtl/riscv_defs.sv
// Shared definitions for the CSR/trap scheduler.
// Holds the bus widths, FSM state and take encodings, interrupt cause codes,
// CSR op encodings, the lane/port/trap payload structs and the helpers that
// build port and trap payloads from a lane.
package riscv_defs;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CSR_AW  = 12;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned CAUSE_W = 4;
    localparam int unsigned IRQ_W   = 3;
    localparam int unsigned CNT_W   = 4;

    // CSR op encodings (funct3 of CSRRW/CSRRS/CSRRC)
    localparam logic [OP_W-1:0] CSR_OP_RW = 3'b001;
    localparam logic [OP_W-1:0] CSR_OP_RS = 3'b010;
    localparam logic [OP_W-1:0] CSR_OP_RC = 3'b011;

    // Machine interrupt cause codes
    localparam logic [CAUSE_W-1:0] CAUSE_MSI = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_MTI = 4'd7;
    localparam logic [CAUSE_W-1:0] CAUSE_MEI = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_TRAP,
        ST_FLUSH
    } state_e;

    // What IDLE decided to take this cycle, in priority order
    typedef enum logic [2:0] {
        TK_NONE,
        TK_INTR,
        TK_EXC0,
        TK_CSR0,
        TK_EXC1,
        TK_CSR1
    } take_e;

    typedef struct packed {
        logic               csr_valid;
        logic [CSR_AW-1:0]  addr;
        logic [XLEN-1:0]    wdata;
        logic [OP_W-1:0]    op;
        logic               wen;
        logic               exc_valid;
        logic [CAUSE_W-1:0] exc_cause;
        logic [XLEN-1:0]    exc_val;
        logic [XLEN-1:0]    pc;
    } lane_t;

    typedef struct packed {
        logic [CSR_AW-1:0] addr;
        logic [XLEN-1:0]   wdata;
        logic [OP_W-1:0]   op;
        logic              wen;
    } csr_port_t;

    typedef struct packed {
        logic               exc_req;
        logic               intr_req;
        logic [CAUSE_W-1:0] cause;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    val;
    } trap_req_t;

    function automatic csr_port_t lane_port(input lane_t l);
        csr_port_t p;
        p.addr  = l.addr;
        p.wdata = l.wdata;
        p.op    = l.op;
        p.wen   = l.wen;
        return p;
    endfunction

    function automatic trap_req_t lane_trap(input lane_t l);
        trap_req_t t;
        t.exc_req  = 1'b1;
        t.intr_req = 1'b0;
        t.cause    = l.exc_cause;
        t.pc       = l.pc;
        t.val      = l.exc_val;
        return t;
    endfunction

endpackage

// File: rtl/riscv_csr_sched_if.sv
// CSR file port bundle between the scheduler and the CSR file.
// master: scheduler side (drives access and trap requests)
// slave : CSR file side (returns read data, trap vector and mie)
interface riscv_csr_sched_if;
    import riscv_defs::*;

    logic [CSR_AW-1:0]  csr_addr;
    logic [XLEN-1:0]    csr_wdata;
    logic [OP_W-1:0]    csr_op;
    logic               csr_wen;
    logic [XLEN-1:0]    csr_rdata;
    logic               csr_exc_req;
    logic               csr_intr_req;
    logic [CAUSE_W-1:0] csr_cause;
    logic [XLEN-1:0]    csr_exc_pc;
    logic [XLEN-1:0]    csr_exc_val;
    logic [XLEN-1:0]    csr_trap_pc;
    logic               csr_mie;

    modport master (
        output csr_addr, csr_wdata, csr_op, csr_wen,
        output csr_exc_req, csr_intr_req, csr_cause, csr_exc_pc, csr_exc_val,
        input  csr_rdata, csr_trap_pc, csr_mie
    );

    modport slave (
        input  csr_addr, csr_wdata, csr_op, csr_wen,
        input  csr_exc_req, csr_intr_req, csr_cause, csr_exc_pc, csr_exc_val,
        output csr_rdata, csr_trap_pc, csr_mie
    );

endinterface

// File: rtl/riscv_irq_prio.sv
// Interrupt priority encoder: external > software > timer.
// Ports: irq_pending (bit0 sw, bit1 timer, bit2 ext) -> valid, cause.
module riscv_irq_prio
    import riscv_defs::*;
(
    input  logic [IRQ_W-1:0]   irq_pending,
    output logic               valid,
    output logic [CAUSE_W-1:0] cause
);

    always_comb begin
        valid = |irq_pending;
        cause = '0;
        if (irq_pending[2]) begin
            cause = CAUSE_MEI;
        end else if (irq_pending[0]) begin
            cause = CAUSE_MSI;
        end else if (irq_pending[1]) begin
            cause = CAUSE_MTI;
        end
    end

endmodule

// File: rtl/riscv_csr_sched.sv
// Trap and CSR-access scheduler for the dual-issue core.
// Serialises lane 0 / lane 1 CSR accesses onto the single CSR port, takes
// interrupts and lane exceptions, and sequences trap request -> flush ->
// redirect.
// Ports: clk, rst_n (async, active-high), lane 0/1 CSR and exception inputs,
// irq_pending, issue_stall, rsp_* (CSR read response), flush, redirect_*,
// csr (CSR file port bundle, master side).
module riscv_csr_sched
    import riscv_defs::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               l0_csr_valid,
    input  logic [CSR_AW-1:0]  l0_csr_addr,
    input  logic [XLEN-1:0]    l0_csr_wdata,
    input  logic [OP_W-1:0]    l0_csr_op,
    input  logic               l0_csr_wen,
    input  logic               l0_exc_valid,
    input  logic [CAUSE_W-1:0] l0_exc_cause,
    input  logic [XLEN-1:0]    l0_exc_val,
    input  logic [XLEN-1:0]    l0_pc,

    input  logic               l1_csr_valid,
    input  logic [CSR_AW-1:0]  l1_csr_addr,
    input  logic [XLEN-1:0]    l1_csr_wdata,
    input  logic [OP_W-1:0]    l1_csr_op,
    input  logic               l1_csr_wen,
    input  logic               l1_exc_valid,
    input  logic [CAUSE_W-1:0] l1_exc_cause,
    input  logic [XLEN-1:0]    l1_exc_val,
    input  logic [XLEN-1:0]    l1_pc,

    input  logic [IRQ_W-1:0]   irq_pending,

    output logic               issue_stall,
    output logic               rsp_valid,
    output logic               rsp_lane,
    output logic [XLEN-1:0]    rsp_rdata,
    output logic               flush,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,

    riscv_csr_sched_if.master  csr
);

    state_e             state;
    take_e              take_kind;
    logic               take;
    lane_t              l0_in;
    lane_t              l1_in;
    lane_t              pend_l1;
    csr_port_t          port_q;
    trap_req_t          trap_q;
    trap_req_t          intr_trap;
    logic [CNT_W-1:0]   flush_cnt;
    logic               irq_valid;
    logic [CAUSE_W-1:0] irq_cause;

    riscv_irq_prio u_irq_prio (
        .irq_pending (irq_pending),
        .valid       (irq_valid),
        .cause       (irq_cause)
    );

    assign l0_in = '{csr_valid: l0_csr_valid, addr: l0_csr_addr, wdata: l0_csr_wdata,
                     op: l0_csr_op, wen: l0_csr_wen, exc_valid: l0_exc_valid,
                     exc_cause: l0_exc_cause, exc_val: l0_exc_val, pc: l0_pc};
    assign l1_in = '{csr_valid: l1_csr_valid, addr: l1_csr_addr, wdata: l1_csr_wdata,
                     op: l1_csr_op, wen: l1_csr_wen, exc_valid: l1_exc_valid,
                     exc_cause: l1_exc_cause, exc_val: l1_exc_val, pc: l1_pc};

    // Interrupts are reported against the older instruction
    assign intr_trap = '{exc_req: 1'b0, intr_req: 1'b1, cause: irq_cause,
                         pc: l0_pc, val: '0};

    // Take selection; interrupts and mie are only looked at in IDLE
    always_comb begin
        take_kind = TK_NONE;
        if (state == ST_IDLE) begin
            if (csr.csr_mie && irq_valid) begin
                take_kind = TK_INTR;
            end else if (l0_exc_valid) begin
                take_kind = TK_EXC0;
            end else if (l0_csr_valid) begin
                take_kind = TK_CSR0;
            end else if (l1_exc_valid) begin
                take_kind = TK_EXC1;
            end else if (l1_csr_valid) begin
                take_kind = TK_CSR1;
            end
        end
    end

    assign take        = (take_kind != TK_NONE);
    // Held low while reset is asserted so lanes see no stall from stale inputs
    assign issue_stall = !rst_n && ((state != ST_IDLE) || take);

    // CSR port outputs are registered copies of the next-state payload
    assign csr.csr_addr     = port_q.addr;
    assign csr.csr_wdata    = port_q.wdata;
    assign csr.csr_op       = port_q.op;
    assign csr.csr_wen      = port_q.wen;
    assign csr.csr_exc_req  = trap_q.exc_req;
    assign csr.csr_intr_req = trap_q.intr_req;
    assign csr.csr_cause    = trap_q.cause;
    assign csr.csr_exc_pc   = trap_q.pc;
    assign csr.csr_exc_val  = trap_q.val;

    // FSM with registered outputs; every strobe defaults to 0 each cycle
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state          <= ST_IDLE;
            pend_l1        <= '0;
            flush_cnt      <= '0;
            port_q         <= '0;
            trap_q         <= '0;
            rsp_valid      <= 1'b0;
            rsp_lane       <= 1'b0;
            rsp_rdata      <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            port_q         <= '0;
            trap_q         <= '0;
            rsp_valid      <= 1'b0;
            rsp_lane       <= 1'b0;
            rsp_rdata      <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;

            case (state)
                ST_IDLE: begin
                    if (take) begin
                        pend_l1 <= l1_in;
                    end
                    case (take_kind)
                        TK_INTR: begin
                            state  <= ST_TRAP;
                            trap_q <= intr_trap;
                        end
                        TK_EXC0: begin
                            state  <= ST_TRAP;
                            trap_q <= lane_trap(l0_in);
                        end
                        TK_CSR0: begin
                            state  <= ST_ACC0;
                            port_q <= lane_port(l0_in);
                        end
                        TK_EXC1: begin
                            state  <= ST_TRAP;
                            trap_q <= lane_trap(l1_in);
                        end
                        TK_CSR1: begin
                            state  <= ST_ACC1;
                            port_q <= lane_port(l1_in);
                        end
                        default: ;
                    endcase
                end

                // Lane 1 work behind a lane 0 access: exception beats CSR op
                ST_ACC0: begin
                    rsp_valid <= 1'b1;
                    rsp_lane  <= 1'b0;
                    rsp_rdata <= csr.csr_rdata;
                    if (pend_l1.exc_valid) begin
                        state  <= ST_TRAP;
                        trap_q <= lane_trap(pend_l1);
                    end else if (pend_l1.csr_valid) begin
                        state  <= ST_ACC1;
                        port_q <= lane_port(pend_l1);
                    end else begin
                        state  <= ST_IDLE;
                    end
                end

                ST_ACC1: begin
                    rsp_valid <= 1'b1;
                    rsp_lane  <= 1'b1;
                    rsp_rdata <= csr.csr_rdata;
                    state     <= ST_IDLE;
                end

                // Vector is captured straight into the redirect register
                ST_TRAP: begin
                    state          <= ST_FLUSH;
                    flush          <= 1'b1;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= csr.csr_trap_pc;
                    flush_cnt      <= CNT_W'(FLUSH_CYCLES - 1);
                end

                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        flush     <= 1'b1;
                        flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_csr_sched.sv
// Directed bench for riscv_csr_sched with a one-register CSR file stub
// (mscratch at 0x340) and a fixed trap vector.
module tb_riscv_csr_sched;
    import riscv_defs::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               l0_csr_valid, l1_csr_valid;
    logic [CSR_AW-1:0]  l0_csr_addr, l1_csr_addr;
    logic [XLEN-1:0]    l0_csr_wdata, l1_csr_wdata;
    logic [OP_W-1:0]    l0_csr_op, l1_csr_op;
    logic               l0_csr_wen, l1_csr_wen;
    logic               l0_exc_valid, l1_exc_valid;
    logic [CAUSE_W-1:0] l0_exc_cause, l1_exc_cause;
    logic [XLEN-1:0]    l0_exc_val, l1_exc_val;
    logic [XLEN-1:0]    l0_pc, l1_pc;
    logic [IRQ_W-1:0]   irq_pending;
    logic               mie;
    logic               issue_stall, rsp_valid, rsp_lane, flush, redirect_valid;
    logic [XLEN-1:0]    rsp_rdata, redirect_pc;
    logic [XLEN-1:0]    mscratch;
    logic [XLEN-1:0]    trap_vec;
    int                 n_cmp = 0;
    int                 n_err = 0;

    always #5 clk = ~clk;

    riscv_csr_sched_if csr_if ();

    riscv_csr_sched #(.FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .l0_csr_valid   (l0_csr_valid),
        .l0_csr_addr    (l0_csr_addr),
        .l0_csr_wdata   (l0_csr_wdata),
        .l0_csr_op      (l0_csr_op),
        .l0_csr_wen     (l0_csr_wen),
        .l0_exc_valid   (l0_exc_valid),
        .l0_exc_cause   (l0_exc_cause),
        .l0_exc_val     (l0_exc_val),
        .l0_pc          (l0_pc),
        .l1_csr_valid   (l1_csr_valid),
        .l1_csr_addr    (l1_csr_addr),
        .l1_csr_wdata   (l1_csr_wdata),
        .l1_csr_op      (l1_csr_op),
        .l1_csr_wen     (l1_csr_wen),
        .l1_exc_valid   (l1_exc_valid),
        .l1_exc_cause   (l1_exc_cause),
        .l1_exc_val     (l1_exc_val),
        .l1_pc          (l1_pc),
        .irq_pending    (irq_pending),
        .issue_stall    (issue_stall),
        .rsp_valid      (rsp_valid),
        .rsp_lane       (rsp_lane),
        .rsp_rdata      (rsp_rdata),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .csr            (csr_if)
    );

    // CSR file stub: only mscratch is implemented
    assign csr_if.csr_rdata   = (csr_if.csr_addr == 12'h340) ? mscratch : 32'h0;
    assign csr_if.csr_trap_pc = trap_vec;
    assign csr_if.csr_mie     = mie;

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mscratch <= '0;
        end else if (csr_if.csr_wen && csr_if.csr_addr == 12'h340) begin
            case (csr_if.csr_op)
                CSR_OP_RW: mscratch <= csr_if.csr_wdata;
                CSR_OP_RS: mscratch <= mscratch | csr_if.csr_wdata;
                CSR_OP_RC: mscratch <= mscratch & ~csr_if.csr_wdata;
                default:   ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        l0_csr_valid = 0; l0_csr_addr = '0; l0_csr_wdata = '0; l0_csr_op = '0; l0_csr_wen = 0;
        l0_exc_valid = 0; l0_exc_cause = '0; l0_exc_val = '0; l0_pc = '0;
        l1_csr_valid = 0; l1_csr_addr = '0; l1_csr_wdata = '0; l1_csr_op = '0; l1_csr_wen = 0;
        l1_exc_valid = 0; l1_exc_cause = '0; l1_exc_val = '0; l1_pc = '0;
        irq_pending = '0; mie = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        trap_vec = 32'h80;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall",     issue_stall,         32'd0);
        chk("rst_rsp_valid", rsp_valid,           32'd0);
        chk("rst_flush",     flush,               32'd0);
        chk("rst_redirect",  redirect_valid,      32'd0);
        chk("rst_csr_wen",   csr_if.csr_wen,      32'd0);
        chk("rst_exc_req",   csr_if.csr_exc_req,  32'd0);
        chk("rst_intr_req",  csr_if.csr_intr_req, 32'd0);
        @(negedge clk); rst_n = 1'b0;

        // Single l0 CSRRW 0x340 <- 0xDEADBEEF
        @(negedge clk);
        l0_csr_valid = 1; l0_csr_addr = 12'h340; l0_csr_wdata = 32'hDEADBEEF;
        l0_csr_op = CSR_OP_RW; l0_csr_wen = 1;
        #1;
        chk("t1_stall_T",   issue_stall,    32'd1);
        chk("t1_wen_T",     csr_if.csr_wen, 32'd0);
        tick(); clear_inputs(); #1;
        chk("t1_wen_T1",    csr_if.csr_wen,   32'd1);
        chk("t1_addr_T1",   csr_if.csr_addr,  32'h340);
        chk("t1_wdata_T1",  csr_if.csr_wdata, 32'hDEADBEEF);
        chk("t1_op_T1",     csr_if.csr_op,    32'(CSR_OP_RW));
        chk("t1_stall_T1",  issue_stall,      32'd1);
        chk("t1_rspv_T1",   rsp_valid,        32'd0);
        tick();
        chk("t1_rspv_T2",   rsp_valid,      32'd1);
        chk("t1_lane_T2",   rsp_lane,       32'd0);
        chk("t1_rdata_T2",  rsp_rdata,      32'd0);
        chk("t1_stall_T2",  issue_stall,    32'd0);
        chk("t1_wen_T2",    csr_if.csr_wen, 32'd0);
        chk("t1_csrval",    mscratch,       32'hDEADBEEF);

        // Dual: l0 CSRRW 0x5, l1 CSRRS 0x2 on 0x340
        @(negedge clk);
        l0_csr_valid = 1; l0_csr_addr = 12'h340; l0_csr_wdata = 32'h5; l0_csr_op = CSR_OP_RW; l0_csr_wen = 1;
        l1_csr_valid = 1; l1_csr_addr = 12'h340; l1_csr_wdata = 32'h2; l1_csr_op = CSR_OP_RS; l1_csr_wen = 1;
        #1;
        chk("t2_stall_T",   issue_stall, 32'd1);
        tick(); clear_inputs(); #1;
        chk("t2_op_T1",     csr_if.csr_op,    32'(CSR_OP_RW));
        chk("t2_wdata_T1",  csr_if.csr_wdata, 32'h5);
        tick();
        chk("t2_op_T2",     csr_if.csr_op,    32'(CSR_OP_RS));
        chk("t2_wdata_T2",  csr_if.csr_wdata, 32'h2);
        chk("t2_wen_T2",    csr_if.csr_wen,   32'd1);
        chk("t2_rspv_T2",   rsp_valid,        32'd1);
        chk("t2_lane_T2",   rsp_lane,         32'd0);
        chk("t2_rdata_T2",  rsp_rdata,        32'hDEADBEEF);
        chk("t2_stall_T2",  issue_stall,      32'd1);
        tick();
        chk("t2_rspv_T3",   rsp_valid,   32'd1);
        chk("t2_lane_T3",   rsp_lane,    32'd1);
        chk("t2_rdata_T3",  rsp_rdata,   32'h5);
        chk("t2_csrval",    mscratch,    32'h7);
        chk("t2_stall_T3",  issue_stall, 32'd0);

        // l0 exception cause 2 at pc 0x100
        @(negedge clk);
        l0_exc_valid = 1; l0_exc_cause = 4'd2; l0_pc = 32'h100; l0_exc_val = 32'h55;
        #1;
        chk("t3_stall_T",   issue_stall, 32'd1);
        tick(); clear_inputs(); #1;
        chk("t3_exc_T1",    csr_if.csr_exc_req,  32'd1);
        chk("t3_intr_T1",   csr_if.csr_intr_req, 32'd0);
        chk("t3_cause_T1",  csr_if.csr_cause,    32'd2);
        chk("t3_pc_T1",     csr_if.csr_exc_pc,   32'h100);
        chk("t3_val_T1",    csr_if.csr_exc_val,  32'h55);
        chk("t3_flush_T1",  flush,               32'd0);
        tick();
        chk("t3_exc_T2",    csr_if.csr_exc_req,  32'd0);
        chk("t3_cause_T2",  csr_if.csr_cause,    32'd0);
        chk("t3_flush_T2",  flush,               32'd1);
        chk("t3_redir_T2",  redirect_valid,      32'd1);
        chk("t3_rpc_T2",    redirect_pc,         32'h80);
        tick();
        chk("t3_flush_T3",  flush,          32'd1);
        chk("t3_redir_T3",  redirect_valid, 32'd0);
        chk("t3_rpc_T3",    redirect_pc,    32'd0);
        chk("t3_stall_T3",  issue_stall,    32'd1);
        tick();
        chk("t3_flush_T4",  flush,          32'd0);
        chk("t3_stall_T4",  issue_stall,    32'd0);

        // All irqs with mie, plus a simultaneous l0 exception: external wins
        @(negedge clk);
        irq_pending = 3'b111; mie = 1;
        l0_exc_valid = 1; l0_exc_cause = 4'd4; l0_pc = 32'h200; l0_exc_val = 32'h99;
        tick(); clear_inputs(); #1;
        chk("t4_intr_T1",   csr_if.csr_intr_req, 32'd1);
        chk("t4_exc_T1",    csr_if.csr_exc_req,  32'd0);
        chk("t4_cause_T1",  csr_if.csr_cause,    32'd11);
        chk("t4_pc_T1",     csr_if.csr_exc_pc,   32'h200);
        chk("t4_val_T1",    csr_if.csr_exc_val,  32'd0);
        tick();
        chk("t4_rpc_T2",    redirect_pc, 32'h80);
        repeat (2) tick();
        chk("t4_stall_T4",  issue_stall, 32'd0);

        // Interrupts pending but mie=0: l0 read of 0x340 proceeds
        @(negedge clk);
        irq_pending = 3'b111; mie = 0;
        l0_csr_valid = 1; l0_csr_addr = 12'h340; l0_csr_op = CSR_OP_RS; l0_csr_wen = 0;
        tick(); clear_inputs(); #1;
        chk("t5_intr_T1",   csr_if.csr_intr_req, 32'd0);
        chk("t5_addr_T1",   csr_if.csr_addr,     32'h340);
        chk("t5_wen_T1",    csr_if.csr_wen,      32'd0);
        tick();
        chk("t5_rdata_T2",  rsp_rdata, 32'h7);

        // Software + timer pending: software wins
        @(negedge clk);
        irq_pending = 3'b011; mie = 1; l0_pc = 32'h260;
        tick(); clear_inputs(); #1;
        chk("t6_cause_T1",  csr_if.csr_cause,    32'd3);
        chk("t6_intr_T1",   csr_if.csr_intr_req, 32'd1);
        repeat (3) tick();
        chk("t6_stall_T4",  issue_stall, 32'd0);

        // l0 CSR read + l1 exception cause 5 (l1 CSR also valid, exception wins)
        @(negedge clk);
        l0_csr_valid = 1; l0_csr_addr = 12'h340; l0_csr_op = CSR_OP_RS; l0_csr_wen = 0; l0_pc = 32'h300;
        l1_csr_valid = 1; l1_csr_addr = 12'h340; l1_csr_op = CSR_OP_RW; l1_csr_wen = 1; l1_csr_wdata = 32'hF;
        l1_exc_valid = 1; l1_exc_cause = 4'd5; l1_pc = 32'h304; l1_exc_val = 32'h77;
        tick(); clear_inputs(); #1;
        chk("t7_addr_T1",   csr_if.csr_addr,    32'h340);
        chk("t7_exc_T1",    csr_if.csr_exc_req, 32'd0);
        tick();
        chk("t7_exc_T2",    csr_if.csr_exc_req, 32'd1);
        chk("t7_cause_T2",  csr_if.csr_cause,   32'd5);
        chk("t7_pc_T2",     csr_if.csr_exc_pc,  32'h304);
        chk("t7_val_T2",    csr_if.csr_exc_val, 32'h77);
        chk("t7_wen_T2",    csr_if.csr_wen,     32'd0);
        chk("t7_addr_T2",   csr_if.csr_addr,    32'd0);
        chk("t7_rspv_T2",   rsp_valid,          32'd1);
        chk("t7_rdata_T2",  rsp_rdata,          32'h7);
        tick();
        chk("t7_redir_T3",  redirect_valid, 32'd1);
        tick();
        chk("t7_flush_T4",  flush,          32'd1);
        tick();
        chk("t7_stall_T5",  issue_stall,    32'd0);
        chk("t7_csrval",    mscratch,       32'h7);

        // Reset asserted during FLUSH
        @(negedge clk);
        l0_exc_valid = 1; l0_exc_cause = 4'd2; l0_pc = 32'h400;
        tick(); clear_inputs();
        tick();
        chk("t8_flush_pre", flush, 32'd1);
        rst_n = 1'b1; #1;
        chk("t8_flush_rst", flush,          32'd0);
        chk("t8_redir_rst", redirect_valid, 32'd0);
        chk("t8_rpc_rst",   redirect_pc,    32'd0);
        chk("t8_stall_rst", issue_stall,    32'd0);
        @(negedge clk); rst_n = 1'b0;

        // Reset asserted during TRAP
        @(negedge clk);
        l0_exc_valid = 1; l0_exc_cause = 4'd6; l0_pc = 32'h500;
        tick(); clear_inputs(); #1;
        chk("t9_exc_pre",   csr_if.csr_exc_req, 32'd1);
        rst_n = 1'b1; #1;
        chk("t9_exc_rst",   csr_if.csr_exc_req, 32'd0);
        chk("t9_cause_rst", csr_if.csr_cause,   32'd0);
        chk("t9_pc_rst",    csr_if.csr_exc_pc,  32'd0);
        chk("t9_stall_rst", issue_stall,        32'd0);
        @(negedge clk); rst_n = 1'b0;
        tick();
        chk("t9_flush_after", flush,          32'd0);
        chk("t9_redir_after", redirect_valid, 32'd0);

        // Normal take after reset: l1-only CSRRW 0x9
        @(negedge clk);
        l1_csr_valid = 1; l1_csr_addr = 12'h340; l1_csr_wdata = 32'h9; l1_csr_op = CSR_OP_RW; l1_csr_wen = 1;
        #1;
        chk("t10_stall_T",  issue_stall, 32'd1);
        tick(); clear_inputs(); #1;
        chk("t10_wdata_T1", csr_if.csr_wdata, 32'h9);
        chk("t10_wen_T1",   csr_if.csr_wen,   32'd1);
        tick();
        chk("t10_rspv_T2",  rsp_valid, 32'd1);
        chk("t10_lane_T2",  rsp_lane,  32'd1);
        chk("t10_rdata_T2", rsp_rdata, 32'd0);
        chk("t10_csrval",   mscratch,  32'h9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_csr_sched.md
# riscv_csr_sched

Trap and CSR-access scheduler for the dual-issue core. It sits between the two issue lanes and the single-ported CSR file. It serialises CSR instructions from lane 0 and lane 1 onto the one CSR port, and prioritises interrupts and per-lane exceptions. It then sequences a trap as follows: a one-cycle trap request to the CSR file, then a pipeline flush, then a redirect to the trap vector.

## Interface
- FLUSH_CYCLES, default 2: cycles flush stays asserted after a trap; legal range 1–15.
- clk  in  1  core clock.
- rst_n  in  1  reset; the single clock is clk; reset is asynchronous and active-high (asserted when 1, despite the name).
- l0_csr_valid / l1_csr_valid  in  1  lane has a CSR instruction at issue.
- l0_csr_addr / l1_csr_addr  in  12  CSR address.
- l0_csr_wdata / l1_csr_wdata  in  32  source operand.
- l0_csr_op / l1_csr_op  in  3  CSRRW/CSRRS/CSRRC encoding, passed through to the CSR file.
- l0_csr_wen / l1_csr_wen  in  1  write enable (0 for read-only forms).
- l0_exc_valid / l1_exc_valid  in  1  lane raises a synchronous exception.
- l0_exc_cause / l1_exc_cause  in  4  exception cause.
- l0_exc_val / l1_exc_val  in  32  trap value.
- l0_pc / l1_pc  in  32  PC of each lane's instruction; l0 is the older one.
- irq_pending  in  3  bit0 = software (cause 3), bit1 = timer (cause 7), bit2 = external (cause 11).
- csr_mie  in  1  global machine interrupt enable from the CSR file.
- issue_stall  out  1  lanes must hold while this is high.
- rsp_valid  out  1  CSR read data is valid this cycle.
- rsp_lane  out  1  which lane the response belongs to.
- rsp_rdata  out  32  CSR old value.
- csr_addr  out  12  CSR port address.
- csr_wdata  out  32  CSR port write data.
- csr_op  out  3  CSR port operation.
- csr_wen  out  1  CSR port write enable.
- csr_rdata  in  32  CSR port read data.
- csr_exc_req  out  1  exception trap request to the CSR file.
- csr_intr_req  out  1  interrupt trap request to the CSR file.
- csr_cause  out  4  trap cause.
- csr_exc_pc  out  32  PC saved on trap.
- csr_exc_val  out  32  trap value saved on trap.
- csr_trap_pc  in  32  trap vector from the CSR file.
- flush  out  1  flush the pipeline.
- redirect_valid  out  1  fetch redirect strobe.
- redirect_pc  out  32  redirect target.

## Operation
- States: IDLE, ACC0, ACC1, TRAP, FLUSH.
- In IDLE, the block evaluates one "take" per cycle in this priority order:
  - 1: interrupt if csr_mie and |irq_pending. Priority is external > software > timer. The saved PC is l0_pc.
  - 2: l0_exc_valid goes to TRAP with the lane 0 fields.
  - 3: l0_csr_valid goes to ACC0.
  - 4: l1_exc_valid goes to TRAP with the lane 1 fields.
  - 5: l1_csr_valid goes to ACC1.
- On any take, all lane inputs are latched. Lane 1 work that follows a lane 0 CSR operation is remembered:
  - ACC0 goes to ACC1 if l1_csr_valid was latched.
  - ACC0 goes to TRAP if l1_exc_valid was latched; an exception beats a CSR operation on lane 1.
  - Otherwise ACC0 goes to IDLE.
- ACC0 and ACC1 last one cycle each:
  - csr_addr, csr_wdata, csr_op and csr_wen are driven from the latched request.
  - csr_rdata is registered at the end of the cycle.
  - rsp_valid pulses the next cycle with rsp_lane and rsp_rdata.
  - ACC1 goes to IDLE.
- TRAP lasts one cycle:
  - csr_exc_req or csr_intr_req is high, together with csr_cause, csr_exc_pc and csr_exc_val.
  - csr_trap_pc is sampled at the end of the cycle.
  - TRAP then goes to FLUSH.
- FLUSH:
  - flush is high for FLUSH_CYCLES cycles, counted by a down-counter.
  - redirect_valid and redirect_pc (the sampled vector) are high in the first FLUSH cycle only.
  - FLUSH then goes to IDLE.
- issue_stall = (state != IDLE) | take.
- All csr_* outputs come only from state and latches; there is no combinational path from inputs to csr_*. In states where a csr_* output is unused, it drives 0.

## Timing
- Reset (async, mid-operation included):
  - State returns to IDLE and all latches and counters clear.
  - Every output is 0 and issue_stall is 0.
  - A trap in progress is abandoned; no partial request is emitted.
- Latencies:
  - Single CSR operation: take at T, port access at T+1, rsp_valid at T+2.
  - Dual CSR operation: port accesses at T+1 and T+2, responses at T+2 and T+3. The lane 1 operation observes the lane 0 write.
  - Trap: request at T+1, flush from T+2 to T+1+FLUSH_CYCLES, redirect at T+2, back in IDLE at T+2+FLUSH_CYCLES.
- irq_pending and csr_mie are sampled only in IDLE. An interrupt that arrives during ACC, TRAP or FLUSH waits.
- When an interrupt coincides with a lane exception, the interrupt wins and the lane exception is discarded; it re-raises after the redirect.

## Structure
- Shared package/defines (riscv_defs):
  - State encodings.
  - Interrupt cause codes 3, 7 and 11.
  - CSR op encodings.
- One natural sub-module: riscv_irq_prio, a combinational 3-to-1 priority encoder from irq_pending to {valid, cause}.

## Test plan
- l0 CSRRW to addr 0x340 with wdata 0xDEADBEEF, old value 0x0 → csr_wen=1 at T+1; rsp_valid with rsp_lane=0 and rsp_rdata=0 at T+2; issue_stall high from T to T+1.
- Both lanes CSRRW then CSRRS on 0x340, with wdata 0x5 then 0x2 → lane 1 response returns 0x5 at T+3; final CSR value 0x7.
- l0_exc_valid with cause 2, pc 0x100, and csr_trap_pc 0x80 → csr_exc_req for one cycle with cause 2 and pc 0x100; redirect_pc=0x80 at T+2; flush for 2 cycles.
- irq_pending=3'b111 with csr_mie=1, simultaneous l0 exception, l0_pc 0x200 → csr_intr_req with cause 11 and csr_exc_pc 0x200; no exc_req.
- l0 CSR operation plus l1 exception with cause 5 → ACC0, then a trap with the lane 1 PC and cause 5.
- rst_n asserted during FLUSH and during TRAP → all outputs 0 immediately; the next IDLE take behaves normally.
